// File: rtl/traffic_ctrl_param.sv
// Density-driven N-road traffic light controller with emergency preemption.
// Define PED_CROSS_EN to add the pedestrian WALK phase (ped_req / ped_walk).

module traffic_ctrl_param_road #(
  parameter int NUM_LANES = 3,
  parameter int CW        = 2
) (
  input  logic [NUM_LANES-1:0] sense,
  output logic [CW-1:0]        density
);
  always_comb begin
    density = '0;
    for (int l = 0; l < NUM_LANES; l++) density = density + CW'(sense[l]);
  end
endmodule

module traffic_ctrl_param #(
  parameter int NUM_ROADS     = 4,
  parameter int NUM_LANES     = 3,
  parameter int MIN_GREEN     = 4,
  parameter int GREEN_PER_CAR = 2,
  parameter int MAX_GREEN     = 10,
  parameter int YELLOW_TIME   = 2,
  parameter int ALLRED_TIME   = 1,
  parameter int EMERG_MIN     = 3
`ifdef PED_CROSS_EN
  , parameter int PED_TIME    = 4
`endif
) (
  input  logic                           clock,
  input  logic                           clear,
`ifdef PED_CROSS_EN
  input  logic                           ped_req,
  output logic                           ped_walk,
`endif
  input  logic [NUM_ROADS*NUM_LANES-1:0] lane_sense,
  input  logic [NUM_ROADS-1:0]           emergency,
  output logic [NUM_ROADS*NUM_LANES-1:0] lane_go,
  output logic [NUM_ROADS-1:0]           yellow,
  output logic [$clog2(NUM_ROADS)-1:0]   active_road,
  output logic [2:0]                     state,
  output logic [$clog2(NUM_LANES+1)-1:0] max_density
);
  localparam int RW = $clog2(NUM_ROADS);
  localparam int CW = $clog2(NUM_LANES+1);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

`ifdef PED_CROSS_EN
  localparam int PED_T = PED_TIME;
`else
  localparam int PED_T = 1;
`endif
  // One timer serves every phase, so size it for the longest one.
  localparam int TMAX = imax(imax(imax(MAX_GREEN, YELLOW_TIME), imax(ALLRED_TIME, EMERG_MIN)), PED_T);
  localparam int TMW  = $clog2(TMAX+1);
  localparam logic [TMW-1:0] Y_LD = TMW'(YELLOW_TIME-1);
  localparam logic [TMW-1:0] A_LD = TMW'(ALLRED_TIME-1);
  localparam logic [TMW-1:0] E_LD = TMW'(EMERG_MIN-1);
  localparam logic [TMW-1:0] W_LD = TMW'(PED_T-1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_GREEN = 3'd1, S_YELLOW = 3'd2,
    S_ALLRED = 3'd3, S_EMERG = 3'd4, S_WALK = 3'd5
  } st_t;

  st_t                            st;
  logic [TMW-1:0]                 timer;
  logic [NUM_ROADS-1:0][CW-1:0]   dens;
  logic                           any_emerg, exit_now, do_sel;
  logic [RW-1:0]                  em_road, gr_road, ix;
  logic [CW-1:0]                  gr_dens;
  int                             idx;

  assign state = st;

  for (genvar r = 0; r < NUM_ROADS; r++) begin : g_road
    traffic_ctrl_param_road #(.NUM_LANES(NUM_LANES), .CW(CW)) u_road (
      .sense   (lane_sense[r*NUM_LANES +: NUM_LANES]),
      .density (dens[r])
    );
  end

  function automatic logic [NUM_ROADS*NUM_LANES-1:0] lane_mask(input logic [RW-1:0] r);
    logic [NUM_ROADS*NUM_LANES-1:0] m;
    m = '0;
    m[int'(r)*NUM_LANES +: NUM_LANES] = '1;
    return m;
  endfunction

  function automatic logic [NUM_ROADS-1:0] road_bit(input logic [RW-1:0] r);
    logic [NUM_ROADS-1:0] b;
    b = '0;
    b[r] = 1'b1;
    return b;
  endfunction

  function automatic logic [TMW-1:0] green_ld(input logic [CW-1:0] d);
    int t;
    t = MIN_GREEN + int'(d) * GREEN_PER_CAR;
    if (t > MAX_GREEN) t = MAX_GREEN;
    return TMW'(t - 1);
  endfunction

  // Rotating scan from active_road+1; strict '>' keeps the first road found on ties.
  always_comb begin
    any_emerg = |emergency;
    em_road   = '0;
    for (int r = NUM_ROADS-1; r >= 0; r--) if (emergency[r]) em_road = RW'(r);
    gr_road = active_road;
    gr_dens = '0;
    idx     = 0;
    ix      = '0;
    for (int k = 1; k <= NUM_ROADS; k++) begin
      idx = int'(active_road) + k;
      if (idx >= NUM_ROADS) idx = idx - NUM_ROADS;
      ix = RW'(idx);
      if (dens[ix] > gr_dens) begin
        gr_dens = dens[ix];
        gr_road = ix;
      end
    end
  end

  assign exit_now = (timer == '0);
  assign do_sel   = (st == S_IDLE) || (st == S_ALLRED && exit_now);

`ifdef PED_CROSS_EN
  logic ped_pend;
  always_ff @(posedge clock) begin
    if (clear)                                          ped_pend <= 1'b0;
    else if (st == S_WALK && (any_emerg || exit_now))   ped_pend <= 1'b0;
    else                                                ped_pend <= ped_pend | ped_req;
  end
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      st          <= S_IDLE;
      timer       <= '0;
      lane_go     <= '0;
      yellow      <= '0;
      active_road <= '0;
      max_density <= '0;
`ifdef PED_CROSS_EN
      ped_walk    <= 1'b0;
`endif
    end else if (do_sel) begin
      if (any_emerg) begin
        st          <= S_EMERG;
        timer       <= E_LD;
        active_road <= em_road;
        max_density <= dens[em_road];
        lane_go     <= lane_mask(em_road);
      end
`ifdef PED_CROSS_EN
      else if (st == S_ALLRED && ped_pend) begin
        st       <= S_WALK;
        timer    <= W_LD;
        ped_walk <= 1'b1;
      end
`endif
      else if (gr_dens != '0) begin
        st          <= S_GREEN;
        timer       <= green_ld(gr_dens);
        active_road <= gr_road;
        max_density <= gr_dens;
        lane_go     <= lane_mask(gr_road);
      end else begin
        st    <= S_IDLE;
        timer <= '0;
      end
    end else begin
      case (st)
        S_GREEN: begin
          // Same-road emergency keeps the lights on; any other one truncates green.
          if (emergency[active_road]) begin
            st    <= S_EMERG;
            timer <= E_LD;
          end else if (any_emerg || exit_now) begin
            st      <= S_YELLOW;
            timer   <= Y_LD;
            lane_go <= '0;
            yellow  <= road_bit(active_road);
          end else timer <= timer - TMW'(1);
        end
        S_YELLOW: begin
          if (exit_now) begin
            st     <= S_ALLRED;
            timer  <= A_LD;
            yellow <= '0;
          end else timer <= timer - TMW'(1);
        end
        S_ALLRED: timer <= timer - TMW'(1);
        S_EMERG: begin
          if (!exit_now) timer <= timer - TMW'(1);
          else if (!emergency[active_road]) begin
            st      <= S_YELLOW;
            timer   <= Y_LD;
            lane_go <= '0;
            yellow  <= road_bit(active_road);
          end
        end
`ifdef PED_CROSS_EN
        S_WALK: begin
          if (any_emerg || exit_now) begin
            st       <= S_ALLRED;
            timer    <= A_LD;
            ped_walk <= 1'b0;
          end else timer <= timer - TMW'(1);
        end
`endif
        default: begin
          st      <= S_IDLE;
          timer   <= '0;
          lane_go <= '0;
          yellow  <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Randomized scoreboard bench for traffic_ctrl_param against a phase/duration
// reference model; monitor pops one expected output set per clock.

module tb_traffic_ctrl_param;
  localparam int NR = 4, NL = 3, MIN_G = 4, GPC = 2, MAX_G = 10;
  localparam int YT = 2, AT = 1, EM = 3, PT = 4;
  localparam int RW = $clog2(NR), CW = $clog2(NL+1);
  localparam int P_IDLE = 0, P_GREEN = 1, P_YEL = 2, P_RED = 3, P_EMG = 4, P_WALK = 5;

  logic              clock = 1'b0;
  logic              clear;
  logic [NR*NL-1:0]  lane_sense;
  logic [NR-1:0]     emergency;
  logic [NR*NL-1:0]  lane_go;
  logic [NR-1:0]     yellow;
  logic [RW-1:0]     active_road;
  logic [2:0]        state;
  logic [CW-1:0]     max_density;
  logic              ped_req;
`ifdef PED_CROSS_EN
  logic              ped_walk;
`endif

  always #5 clock = ~clock;

  traffic_ctrl_param #(
    .NUM_ROADS(NR), .NUM_LANES(NL), .MIN_GREEN(MIN_G), .GREEN_PER_CAR(GPC),
    .MAX_GREEN(MAX_G), .YELLOW_TIME(YT), .ALLRED_TIME(AT), .EMERG_MIN(EM)
`ifdef PED_CROSS_EN
    , .PED_TIME(PT)
`endif
  ) dut (
    .clock       (clock),
    .clear       (clear),
`ifdef PED_CROSS_EN
    .ped_req     (ped_req),
    .ped_walk    (ped_walk),
`endif
    .lane_sense  (lane_sense),
    .emergency   (emergency),
    .lane_go     (lane_go),
    .yellow      (yellow),
    .active_road (active_road),
    .state       (state),
    .max_density (max_density)
  );

  typedef struct {
    logic [2:0]       st;
    logic [NR*NL-1:0] go;
    logic [NR-1:0]    y;
    logic [RW-1:0]    road;
    logic [CW-1:0]    md;
    logic             pw;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0, miscompares = 0;

  // Reference model: current phase, cycles already spent in it, phase length.
  int m_st = P_IDLE, m_cyc = 0, m_dur = 0, m_road = 0, m_md = 0;
  bit m_ped = 0;

  function automatic int green_dur(input int d);
    return (MIN_G + d*GPC > MAX_G) ? MAX_G : MIN_G + d*GPC;
  endfunction

  task automatic go_phase(input int s, input int dur);
    m_st = s; m_dur = dur; m_cyc = 0;
  endtask

  task automatic model_step();
    int   d[NR];
    int   er, maxd, pick, r;
    bit   done, old_ped, leave_walk, pr;
    exp_t e;
    pr = 1'b0;
`ifdef PED_CROSS_EN
    pr = ped_req;
`endif
    if (clear) begin
      m_st = P_IDLE; m_cyc = 0; m_dur = 0; m_road = 0; m_md = 0; m_ped = 0;
    end else begin
      for (int i = 0; i < NR; i++) d[i] = $countones(lane_sense[i*NL +: NL]);
      er = -1;
      for (int i = 0; i < NR; i++) if (emergency[i] && er < 0) er = i;
      maxd = 0;
      for (int i = 0; i < NR; i++) if (d[i] > maxd) maxd = d[i];
      pick = -1;
      if (maxd > 0)
        for (int k = 1; k <= NR; k++) begin
          r = (m_road + k) % NR;
          if (pick < 0 && d[r] == maxd) pick = r;
        end
      done       = (m_cyc + 1 >= m_dur);
      old_ped    = m_ped;
      leave_walk = 1'b0;
      if (m_st == P_IDLE || (m_st == P_RED && done)) begin
        if (er >= 0) begin
          go_phase(P_EMG, EM); m_road = er; m_md = d[er];
        end else if (m_st == P_RED && old_ped) begin
          go_phase(P_WALK, PT);
        end else if (pick >= 0) begin
          go_phase(P_GREEN, green_dur(maxd)); m_road = pick; m_md = maxd;
        end else go_phase(P_IDLE, 0);
      end else begin
        case (m_st)
          P_GREEN:
            if (emergency[m_road])     go_phase(P_EMG, EM);
            else if (er >= 0 || done)  go_phase(P_YEL, YT);
            else                       m_cyc++;
          P_YEL:  if (done) go_phase(P_RED, AT); else m_cyc++;
          P_RED:  m_cyc++;
          P_EMG:  if (done && !emergency[m_road]) go_phase(P_YEL, YT); else m_cyc++;
          P_WALK: if (er >= 0 || done) begin go_phase(P_RED, AT); leave_walk = 1'b1; end
                  else m_cyc++;
          default: go_phase(P_IDLE, 0);
        endcase
      end
      m_ped = leave_walk ? 1'b0 : (old_ped | pr);
    end
    e.st   = 3'(m_st);
    e.go   = '0;
    if (m_st == P_GREEN || m_st == P_EMG) e.go[m_road*NL +: NL] = {NL{1'b1}};
    e.y    = '0;
    if (m_st == P_YEL) e.y[m_road] = 1'b1;
    e.road = RW'(m_road);
    e.md   = CW'(m_md);
    e.pw   = (m_st == P_WALK);
    sbq.push_back(e);
  endtask

  // Monitor: one expected entry per edge, checked 2 time units after it.
  initial begin
    exp_t e;
    bit   bad;
    forever begin
      @(posedge clock); #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        vectors++;
        bad = (state !== e.st) || (lane_go !== e.go) || (yellow !== e.y) ||
              (active_road !== e.road) || (max_density !== e.md);
`ifdef PED_CROSS_EN
        bad = bad || (ped_walk !== e.pw);
`endif
        if (bad) begin
          miscompares++;
          $display("FAIL vec%0d t=%0t actual/required: state %0d/%0d lane_go %h/%h yellow %h/%h road %0d/%0d max_density %0d/%0d",
                   vectors, $time, state, e.st, lane_go, e.go, yellow, e.y,
                   active_road, e.road, max_density, e.md);
        end
      end
    end
  end

  initial begin
    int em_hold;
    em_hold    = 0;
    clear      = 1'b1;
    lane_sense = '0;
    emergency  = '0;
    ped_req    = 1'b0;
    // Reset held with random inputs.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      clear = 1'b1; lane_sense = NR*NL'($urandom); emergency = NR'($urandom);
      ped_req = 1'($urandom);
      model_step();
    end
    // Released with no demand: must stay idle.
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      clear = 1'b0; lane_sense = '0; emergency = '0; ped_req = 1'b0;
      model_step();
    end
    // Road0 density 3 and road3 density 2 held steady.
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      lane_sense = 12'h607;
      model_step();
    end
    // Random traffic, emergencies, pedestrian pushes and occasional clears.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if ($urandom_range(0, 7) == 0) lane_sense = NR*NL'($urandom);
      if (em_hold > 0) em_hold--;
      else begin
        emergency = '0;
        if ($urandom_range(0, 39) == 0) begin
          emergency[$urandom_range(0, NR-1)] = 1'b1;
          if ($urandom_range(0, 3) == 0) emergency[$urandom_range(0, NR-1)] = 1'b1;
          em_hold = $urandom_range(0, 8);
        end
      end
      ped_req = ($urandom_range(0, 29) == 0);
      clear   = ($urandom_range(0, 499) == 0);
      model_step();
    end
    @(negedge clock);
    clear = 1'b0;
    for (int w = 0; w < 10 && sbq.size() != 0; w++) begin
      @(posedge clock); #3;
    end
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
